usb_tx_pkt_sequencer: RTL

- Parametrised transmit-side packet sequencer for the USB encryptor.
- Sequences the fields of token, data and handshake packets: SYNC, PID, token body, payload, CRC5/CRC16, EOP, then inter-packet delay.
- Counts bit times from a bit-rate strobe and tells the downstream shift/encode path which field is on the wire.
- Supports variable-length data payloads (0..MAX_DATA_BYTES) and a configurable post-EOP turnaround delay.

---
 rtl/usb_tx_pkg.sv | 60 ++++++
 rtl/usb_tx_bit_counter.sv | 40 ++++
 rtl/usb_tx_pkt_sequencer.sv | 202 ++++++++++++++++++++
 3 files changed

// File: rtl/usb_tx_pkg.sv
// Shared types and field-length constants for the USB transmit packet sequencer.
package usb_tx_pkg;

    typedef enum logic [1:0] {
        PktToken     = 2'd0,
        PktData      = 2'd1,
        PktHandshake = 2'd2,
        PktIllegal   = 2'd3
    } pkt_type_t;

    typedef enum logic [2:0] {
        FieldNone  = 3'd0,
        FieldSync  = 3'd1,
        FieldPid   = 3'd2,
        FieldTbody = 3'd3,
        FieldData  = 3'd4,
        FieldCrc5  = 3'd5,
        FieldCrc16 = 3'd6,
        FieldEop   = 3'd7
    } field_t;

    typedef enum logic [3:0] {
        StIdle, StSync, StPid, StTbody, StData, StCrc5, StCrc16, StEop, StDelay
    } state_t;

    localparam int unsigned SYNC_BITS  = 8;
    localparam int unsigned PID_BITS   = 8;
    localparam int unsigned TBODY_BITS = 11;
    localparam int unsigned CRC5_BITS  = 5;
    localparam int unsigned CRC16_BITS = 16;
    localparam int unsigned EOP_BITS   = 3;

    function automatic field_t state_to_field(state_t st);
        case (st)
            StSync:  return FieldSync;
            StPid:   return FieldPid;
            StTbody: return FieldTbody;
            StData:  return FieldData;
            StCrc5:  return FieldCrc5;
            StCrc16: return FieldCrc16;
            StEop:   return FieldEop;
            default: return FieldNone;
        endcase
    endfunction

    // Index of the last bit of the field; DATA counts per byte.
    function automatic logic [3:0] field_last_bit(state_t st);
        case (st)
            StSync:  return 4'(SYNC_BITS - 1);
            StPid:   return 4'(PID_BITS - 1);
            StTbody: return 4'(TBODY_BITS - 1);
            StData:  return 4'd7;
            StCrc5:  return 4'(CRC5_BITS - 1);
            StCrc16: return 4'(CRC16_BITS - 1);
            StEop:   return 4'(EOP_BITS - 1);
            default: return 4'd0;
        endcase
    endfunction

endpackage

// File: rtl/usb_tx_bit_counter.sv
// Tick-gated up counter with clear, load and a programmable terminal-count flag.
module usb_tx_bit_counter #(
    parameter int unsigned Width = 4
) (
    input  logic             clk,
    input  logic             n_rst,
    input  logic             clr_i,
    input  logic             load_i,
    input  logic [Width-1:0] load_val_i,
    input  logic             tick_i,
    input  logic [Width-1:0] term_val_i,
    output logic [Width-1:0] cnt_o,
    output logic             term_o
);

    logic [Width-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (load_i) begin
            cnt_d = load_val_i;
        end else if (tick_i) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o  = cnt_q;
    assign term_o = (cnt_q == term_val_i);

endmodule

// File: rtl/usb_tx_pkt_sequencer.sv
// Transmit packet field sequencer: SYNC/PID/body/CRC/EOP/turnaround, paced by bit_tick_i.
// Optional abort support is built when USB_TX_ABORT_EN is defined.
module usb_tx_pkt_sequencer
    import usb_tx_pkg::*;
#(
    parameter int unsigned MAX_DATA_BYTES   = 64,
    parameter int unsigned EOP_DELAY_CYCLES = 2,
    parameter int unsigned LEN_W            = $clog2(MAX_DATA_BYTES + 1)
) (
    input  logic             clk,
    input  logic             n_rst,
    input  logic             pkt_start_i,
    input  logic [1:0]       pkt_type_i,
    input  logic [LEN_W-1:0] data_len_i,
    input  logic             bit_tick_i,
`ifdef USB_TX_ABORT_EN
    input  logic             abort_i,
    output logic             pkt_aborted_o,
`endif
    output logic             busy_o,
    output logic             pkt_done_o,
    output logic             start_err_o,
    output logic [2:0]       field_sel_o,
    output logic [3:0]       field_bit_idx_o,
    output logic [LEN_W-1:0] data_byte_idx_o,
    output logic             load_byte_o
);

    localparam int unsigned DlyW = $clog2(EOP_DELAY_CYCLES + 1);

    state_t           state_q, state_d;
    pkt_type_t        type_q, type_d;
    logic [LEN_W-1:0] len_q, len_d;
    logic [LEN_W-1:0] byte_idx_q, byte_idx_d;
    logic [DlyW-1:0]  dly_q, dly_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             err_q, err_d;
    logic             load_q, load_d;
    field_t           field_q, field_d;

    logic       cnt_clr, cnt_term, field_last, req_bad;
    logic [3:0] cnt;

    usb_tx_bit_counter #(
        .Width (4)
    ) u_bit_counter (
        .clk        (clk),
        .n_rst      (n_rst),
        .clr_i      (cnt_clr),
        .load_i     (1'b0),
        .load_val_i (4'd0),
        .tick_i     (bit_tick_i),
        .term_val_i (field_last_bit(state_q)),
        .cnt_o      (cnt),
        .term_o     (cnt_term)
    );

    assign field_last = bit_tick_i & cnt_term;
    // data_len only matters for DATA packets, so only they can be oversized.
    assign req_bad = (pkt_type_i == 2'd3) ||
                     ((pkt_type_i == 2'd1) && (32'(data_len_i) > MAX_DATA_BYTES));

`ifdef USB_TX_ABORT_EN
    logic aborted_q, aborted_d;
`endif

    always_comb begin
        state_d    = state_q;
        type_d     = type_q;
        len_d      = len_q;
        byte_idx_d = byte_idx_q;
        dly_d      = dly_q;
        err_d      = 1'b0;
        done_d     = 1'b0;
        load_d     = 1'b0;
        cnt_clr    = field_last;

        case (state_q)
            StIdle: begin
                cnt_clr = 1'b1;
                if (pkt_start_i) begin
                    if (req_bad) begin
                        err_d = 1'b1;
                    end else begin
                        type_d  = pkt_type_t'(pkt_type_i);
                        len_d   = data_len_i;
                        state_d = StSync;
                    end
                end
            end
            StSync:  if (field_last) state_d = StPid;
            StPid: begin
                if (field_last) begin
                    case (type_q)
                        PktToken: state_d = StTbody;
                        PktData: begin
                            if (len_q == '0) begin
                                state_d = StCrc16;
                            end else begin
                                state_d = StData;
                                load_d  = 1'b1;
                            end
                        end
                        default:  state_d = StEop;
                    endcase
                end
            end
            StTbody: if (field_last) state_d = StCrc5;
            StData: begin
                if (field_last) begin
                    if (LEN_W'(byte_idx_q + 1'b1) == len_q) begin
                        state_d = StCrc16;
                    end else begin
                        byte_idx_d = byte_idx_q + 1'b1;
                        load_d     = 1'b1;
                    end
                end
            end
            StCrc5, StCrc16: if (field_last) state_d = StEop;
            StEop: begin
                if (field_last) begin
                    state_d = StDelay;
                    dly_d   = '0;
                end
            end
            StDelay: begin
                cnt_clr = 1'b1;
                if (dly_q == DlyW'(EOP_DELAY_CYCLES - 1)) begin
                    state_d = StIdle;
                    done_d  = 1'b1;
                end else begin
                    dly_d = dly_q + 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase

`ifdef USB_TX_ABORT_EN
        aborted_d = 1'b0;
        if (abort_i && (state_q inside {StSync, StPid, StTbody, StData, StCrc5, StCrc16})) begin
            state_d   = StEop;
            cnt_clr   = 1'b1;
            load_d    = 1'b0;
            aborted_d = 1'b1;
        end
`endif

        if (state_d != StData) begin
            byte_idx_d = '0;
        end
        busy_d  = (state_d != StIdle);
        field_d = state_to_field(state_d);
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_q    <= StIdle;
            type_q     <= PktToken;
            len_q      <= '0;
            byte_idx_q <= '0;
            dly_q      <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
            load_q     <= 1'b0;
            field_q    <= FieldNone;
        end else begin
            state_q    <= state_d;
            type_q     <= type_d;
            len_q      <= len_d;
            byte_idx_q <= byte_idx_d;
            dly_q      <= dly_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            err_q      <= err_d;
            load_q     <= load_d;
            field_q    <= field_d;
        end
    end

`ifdef USB_TX_ABORT_EN
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            aborted_q <= 1'b0;
        end else begin
            aborted_q <= aborted_d;
        end
    end

    assign pkt_aborted_o = aborted_q;
`endif

    assign busy_o          = busy_q;
    assign pkt_done_o      = done_q;
    assign start_err_o     = err_q;
    assign field_sel_o     = field_q;
    assign field_bit_idx_o = cnt;
    assign data_byte_idx_o = byte_idx_q;
    assign load_byte_o     = load_q;

endmodule
